// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter
// Shares one CSR strobe bus among NUM_REQUESTERS masters. A granted transaction
// runs through a fixed ACCESS window of ACCESS_CYCLES cycles. It then spends one
// DONE cycle, in which read data and a completion pulse go back to the owner.
//
// Build option: define CSR_BUS_ARBITER_FIXED_PRIORITY_EN to replace round-robin
// arbitration with fixed priority (lowest requester index wins). The default
// build, with the macro undefined, is round-robin.
module csr_bus_arbiter #(
    parameter int NUM_REQUESTERS       = 4,
    parameter int CSR_DATA_BUS_WIDTH   = 32,
    parameter int CSR_STROBE_BUS_WIDTH = 8,
    parameter int SEL_WIDTH            = 3,
    parameter int ACCESS_CYCLES        = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQUESTERS-1:0]                      req_i,
    input  logic [NUM_REQUESTERS-1:0]                      rw_i,
    input  logic [NUM_REQUESTERS*SEL_WIDTH-1:0]            sel_i,
    input  logic [NUM_REQUESTERS*CSR_DATA_BUS_WIDTH-1:0]   wdata_i,
    output logic [NUM_REQUESTERS-1:0]                      grant_o,
    output logic [NUM_REQUESTERS-1:0]                      done_o,
    output logic [CSR_DATA_BUS_WIDTH-1:0]                  rdata_o,
    output logic                                           err_o,
    output logic [CSR_STROBE_BUS_WIDTH-1:0]                csr_stb_o,
    output logic [CSR_DATA_BUS_WIDTH-1:0]                  csr_data_o,
    input  logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0] csr_data_i,
    output logic                                           csr_rw_o,
    output logic                                           csr_in_progress_o
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                              state_r, state_s;
    logic [NUM_REQUESTERS-1:0]           grant_r, grant_s;
    logic [NUM_REQUESTERS-1:0]           done_r, done_s;
    logic [CSR_DATA_BUS_WIDTH-1:0]       rdata_r, rdata_s;
    logic                                err_r, err_s;
    logic [CSR_STROBE_BUS_WIDTH-1:0]     stb_r, stb_s;
    logic [CSR_DATA_BUS_WIDTH-1:0]       data_r, data_s;
    logic                                rw_r, rw_s;
    logic                                busy_r, busy_s;
    logic [SEL_WIDTH-1:0]                sel_r, sel_s;
    logic [CNT_W-1:0]                    cnt_r, cnt_s;

    logic                                win_found_s;
    logic [IDX_W-1:0]                    win_idx_s;
    logic                                win_rw_s;
    logic [SEL_WIDTH-1:0]                win_sel_s;
    logic [CSR_DATA_BUS_WIDTH-1:0]       win_wdata_s;

`ifndef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]                    last_grant_r, last_grant_s;
`endif

    // A device index at or beyond the device count addresses nothing.
    function automatic logic sel_oor(input logic [SEL_WIDTH-1:0] s);
        return (32'(s) >= 32'(CSR_STROBE_BUS_WIDTH));
    endfunction

    // One-hot device mask for a select value; all zero when out of range.
    function automatic logic [CSR_STROBE_BUS_WIDTH-1:0] sel_decode(input logic [SEL_WIDTH-1:0] s);
        logic [CSR_STROBE_BUS_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < CSR_STROBE_BUS_WIDTH; i++) begin
            m[i] = (32'(s) == 32'(i));
        end
        return m;
    endfunction

    // Selected device read word; zero when the select is out of range.
    function automatic logic [CSR_DATA_BUS_WIDTH-1:0] dev_read(
        input logic [SEL_WIDTH-1:0]                                s,
        input logic [CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH-1:0]  words
    );
        logic [CSR_STROBE_BUS_WIDTH-1:0] m;
        logic [CSR_DATA_BUS_WIDTH-1:0]   w;
        m = sel_decode(s);
        w = '0;
        for (int i = 0; i < CSR_STROBE_BUS_WIDTH; i++) begin
            w = w | ({CSR_DATA_BUS_WIDTH{m[i]}} & words[i*CSR_DATA_BUS_WIDTH +: CSR_DATA_BUS_WIDTH]);
        end
        return w;
    endfunction

    // Index of the set bit in a one-hot grant vector.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQUESTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Choose the next owner; the loop runs from lowest to highest priority so the last hit wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
`ifdef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
        for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(i);
            end else begin
                win_found_s = win_found_s;
            end
        end
`else
        for (int i = NUM_REQUESTERS; i >= 1; i--) begin
            int cand_v;
            cand_v = (int'(last_grant_r) + i) % NUM_REQUESTERS;
            if (req_i[cand_v]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(cand_v);
            end else begin
                win_found_s = win_found_s;
            end
        end
`endif
        win_rw_s    = rw_i[win_idx_s];
        win_sel_s   = sel_i[win_idx_s*SEL_WIDTH +: SEL_WIDTH];
        win_wdata_s = wdata_i[win_idx_s*CSR_DATA_BUS_WIDTH +: CSR_DATA_BUS_WIDTH];
    end

    // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        done_s  = '0;
        err_s   = 1'b0;
        rdata_s = rdata_r;
        stb_s   = '0;
        data_s  = data_r;
        rw_s    = rw_r;
        busy_s  = busy_r;
        sel_s   = sel_r;
        cnt_s   = cnt_r;
`ifndef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
        last_grant_s = last_grant_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_ACCESS;
                    grant_s = NUM_REQUESTERS'(1) << win_idx_s;
                    rw_s    = win_rw_s;
                    sel_s   = win_sel_s;
                    data_s  = win_wdata_s;
                    cnt_s   = CNT_LOAD;
                    busy_s  = 1'b1;
                    // The strobe is raised only for the first ACCESS cycle, so it is loaded here.
                    stb_s   = win_rw_s ? sel_decode(win_sel_s) : '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == '0) begin
                    state_s = ST_DONE;
                    done_s  = grant_r;
                    err_s   = sel_oor(sel_r);
                    if (!rw_r) begin
                        rdata_s = dev_read(sel_r, csr_data_i);
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
`ifndef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
                last_grant_s = onehot_to_idx(grant_r);
`endif
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and latched transaction fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r <= '0;
            done_r  <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            stb_r   <= '0;
            data_r  <= '0;
            rw_r    <= 1'b0;
            busy_r  <= 1'b0;
            sel_r   <= '0;
            cnt_r   <= '0;
        end else begin
            grant_r <= grant_s;
            done_r  <= done_s;
            rdata_r <= rdata_s;
            err_r   <= err_s;
            stb_r   <= stb_s;
            data_r  <= data_s;
            rw_r    <= rw_s;
            busy_r  <= busy_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
        end
    end

`ifndef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
    // Round-robin pointer; the reset value gives requester 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= IDX_W'(NUM_REQUESTERS - 1);
        end else begin
            last_grant_r <= last_grant_s;
        end
    end
`endif

    assign grant_o           = grant_r;
    assign done_o            = done_r;
    assign rdata_o           = rdata_r;
    assign err_o             = err_r;
    assign csr_stb_o         = stb_r;
    assign csr_data_o        = data_r;
    assign csr_rw_o          = rw_r;
    assign csr_in_progress_o = busy_r;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed, table-driven bench for csr_bus_arbiter (4 requesters, 8 devices,
// 4-bit selects so out-of-range selects can be driven, ACCESS_CYCLES = 2).
module tb_csr_bus_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int NDEV = 8;
    localparam int SW   = 4;
    localparam int AC   = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N-1:0]      rw;
    logic [N*SW-1:0]   sel;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      grant;
    logic [N-1:0]      done;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [NDEV-1:0]   stb;
    logic [DW-1:0]     csr_data;
    logic [NDEV*DW-1:0] dev_data;
    logic              csr_rw;
    logic              busy;

    int cnt_cmp  = 0;
    int cnt_fail = 0;

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    rw;
        logic [N*SW-1:0] sel;
        logic [DW-1:0]   wbase;
        logic [N-1:0]    exp_grant;
        logic [NDEV-1:0] exp_stb;
        logic [DW-1:0]   exp_data;
        logic            exp_rw;
        logic [DW-1:0]   exp_rdata;
        logic            exp_err;
    } vec_t;

    vec_t vecs [10];

    csr_bus_arbiter #(
        .NUM_REQUESTERS      (N),
        .CSR_DATA_BUS_WIDTH  (DW),
        .CSR_STROBE_BUS_WIDTH(NDEV),
        .SEL_WIDTH           (SW),
        .ACCESS_CYCLES       (AC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req),
        .rw_i             (rw),
        .sel_i            (sel),
        .wdata_i          (wdata),
        .grant_o          (grant),
        .done_o           (done),
        .rdata_o          (rdata),
        .err_o            (err),
        .csr_stb_o        (stb),
        .csr_data_o       (csr_data),
        .csr_data_i       (dev_data),
        .csr_rw_o         (csr_rw),
        .csr_in_progress_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] dev_word(input int i);
        if (i == 3) return 32'h0000_CAFE;
        return 32'hD0D0_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cnt_cmp++;
        if (act !== exp) begin
            cnt_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_wdata(input logic [DW-1:0] base);
        for (int k = 0; k < N; k++) begin
            wdata[k*DW +: DW] = base + DW'(k);
        end
    endtask

    // Runs one transaction starting in an IDLE cycle with inputs already driven.
    task automatic run_txn(input string tag, input logic [N-1:0] eg, input logic [NDEV-1:0] es,
                           input logic [DW-1:0] ed, input logic erw, input logic [DW-1:0] er,
                           input logic ee, input bit drop);
        @(posedge clk); #1;
        chk({tag, ".grant"}, DW'(grant), DW'(eg));
        chk({tag, ".stb1"},  DW'(stb),   DW'(es));
        chk({tag, ".wdata"}, csr_data,   ed);
        chk({tag, ".rw"},    DW'(csr_rw), DW'(erw));
        chk({tag, ".busy1"}, DW'(busy),  32'd1);
        chk({tag, ".done1"}, DW'(done),  32'd0);
        if (drop) req = '0;
        @(posedge clk); #1;
        chk({tag, ".stb2"},  DW'(stb),   32'd0);
        chk({tag, ".grant2"}, DW'(grant), DW'(eg));
        chk({tag, ".done2"}, DW'(done),  32'd0);
        @(posedge clk); #1;
        chk({tag, ".done"},  DW'(done),  DW'(eg));
        chk({tag, ".err"},   DW'(err),   DW'(ee));
        chk({tag, ".rdata"}, rdata,      er);
        chk({tag, ".busy3"}, DW'(busy),  32'd1);
        @(posedge clk); #1;
        chk({tag, ".idle_done"},  DW'(done),  32'd0);
        chk({tag, ".idle_grant"}, DW'(grant), 32'd0);
        chk({tag, ".idle_busy"},  DW'(busy),  32'd0);
        chk({tag, ".idle_err"},   DW'(err),   32'd0);
    endtask

    initial begin
        int exp_idx;
        for (int i = 0; i < NDEV; i++) dev_data[i*DW +: DW] = dev_word(i);
        req = '0; rw = '0; sel = '0; wdata = '0;

        //            req      rw       sel       wbase          grant    stb    data           rw    rdata          err
        vecs[0] = '{4'b0100, 4'b0100, 16'h0500, 32'h0000_1232, 4'b0100, 8'h20, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b0};
        vecs[1] = '{4'b0001, 4'b0000, 16'h0003, 32'h1111_0000, 4'b0001, 8'h00, 32'h1111_0000, 1'b0, 32'h0000_CAFE, 1'b0};
        vecs[2] = '{4'b0010, 4'b0000, 16'h0090, 32'h2222_0000, 4'b0010, 8'h00, 32'h2222_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{4'b1000, 4'b0000, 16'h7000, 32'h3333_0000, 4'b1000, 8'h00, 32'h3333_0003, 1'b0, 32'hD0D0_0707, 1'b0};
        vecs[4] = '{4'b0001, 4'b0001, 16'h000C, 32'h4444_0000, 4'b0001, 8'h00, 32'h4444_0000, 1'b1, 32'hD0D0_0707, 1'b1};
        vecs[5] = '{4'b0110, 4'b0110, 16'h0610, 32'h5555_0000, 4'b0010, 8'h02, 32'h5555_0001, 1'b1, 32'hD0D0_0707, 1'b0};
        vecs[6] = '{4'b0110, 4'b0110, 16'h0610, 32'h6666_0000, 4'b0100, 8'h40, 32'h6666_0002, 1'b1, 32'hD0D0_0707, 1'b0};
        vecs[7] = '{4'b1011, 4'b0000, 16'h4020, 32'h7777_0000, 4'b1000, 8'h00, 32'h7777_0003, 1'b0, 32'hD0D0_0404, 1'b0};
        vecs[8] = '{4'b1011, 4'b0000, 16'h4020, 32'h8888_0000, 4'b0001, 8'h00, 32'h8888_0000, 1'b0, 32'hD0D0_0000, 1'b0};
        vecs[9] = '{4'b1011, 4'b0000, 16'h4020, 32'h9999_0000, 4'b0010, 8'h00, 32'h9999_0001, 1'b0, 32'hD0D0_0202, 1'b0};

        // Reset state.
        rst = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst.grant", DW'(grant), 32'd0);
        chk("rst.done",  DW'(done),  32'd0);
        chk("rst.rdata", rdata,      32'd0);
        chk("rst.err",   DW'(err),   32'd0);
        chk("rst.stb",   DW'(stb),   32'd0);
        chk("rst.data",  csr_data,   32'd0);
        chk("rst.rw",    DW'(csr_rw), 32'd0);
        chk("rst.busy",  DW'(busy),  32'd0);
        rst = 1'b0;

`ifndef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
        // Table of single and contended transactions; round-robin state carries across entries.
        for (int v = 0; v < 10; v++) begin
            req = vecs[v].req;
            rw  = vecs[v].rw;
            sel = vecs[v].sel;
            set_wdata(vecs[v].wbase);
            run_txn($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_stb, vecs[v].exp_data,
                    vecs[v].exp_rw, vecs[v].exp_rdata, vecs[v].exp_err, 1'b0);
        end
`endif

        // Reset in the middle of a write ACCESS window.
        req = 4'b0100; rw = 4'b0100; sel = 16'h0500; set_wdata(32'h0000_1232);
        @(posedge clk); #1;
        chk("mid.stb_before", DW'(stb), 32'h0000_0020);
        #1 rst = 1'b1;
        #1;
        chk("mid.stb_async",   DW'(stb),   32'd0);
        chk("mid.grant_async", DW'(grant), 32'd0);
        chk("mid.busy_async",  DW'(busy),  32'd0);
        chk("mid.done_async",  DW'(done),  32'd0);
        req = 4'b1111; rw = 4'b0000; sel = 16'h3210; set_wdata(32'hC000_0000);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // All requesters held high from reset: strictly cyclic order starting at 0.
        for (int t = 0; t < 8; t++) begin
`ifdef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
            exp_idx = 0;
`else
            exp_idx = t % N;
`endif
            run_txn($sformatf("rr%0d", t), N'(1) << exp_idx, 8'h00, 32'hC000_0000 + DW'(exp_idx),
                    1'b0, dev_word(exp_idx), 1'b0, 1'b0);
        end

        // Early release: requester 1 drops its request during ACCESS.
        req = 4'b0010; rw = 4'b0000; sel = 16'h0020; set_wdata(32'hE000_0000);
`ifdef CSR_BUS_ARBITER_FIXED_PRIORITY_EN
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
`else
        run_txn("early", 4'b0010, 8'h00, 32'hE000_0001, 1'b0, dev_word(2), 1'b0, 1'b1);
`endif
        @(posedge clk); #1;
        chk("early.no_regrant", DW'(grant), 32'd0);
        chk("early.no_busy",    DW'(busy),  32'd0);
        @(posedge clk); #1;
        chk("early.no_done",    DW'(done),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
        $finish;
    end

endmodule

// File: doc/csr_bus_arbiter.md
Name: csr_bus_arbiter

Overview:
- Shares one CSR strobe bus among NUM_REQUESTERS masters: one-hot write strobe, common write data, per-device read-data vector.
- Round-robin arbitration; sequences each granted transaction through a fixed access window and returns read data plus a completion pulse to the winner.
- Sits between the CSR test/host masters and the device register banks.

Parameters:
- NUM_REQUESTERS, 4, number of requesting masters (2..8).
- CSR_DATA_BUS_WIDTH, 32, CSR data word width.
- CSR_STROBE_BUS_WIDTH, 8, number of devices, one strobe each.
- SEL_WIDTH, 3, width of each device-select field; must be ≥ clog2(CSR_STROBE_BUS_WIDTH).
- ACCESS_CYCLES, 2, cycles in ACCESS (1..15); read data sampled on the last one.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_i  in  NUM_REQUESTERS  per-requester request level.
- rw_i  in  NUM_REQUESTERS  per-requester direction: 1 = write, 0 = read.
- sel_i  in  NUM_REQUESTERS*SEL_WIDTH  per-requester device index; requester k uses field k.
- wdata_i  in  NUM_REQUESTERS*CSR_DATA_BUS_WIDTH  per-requester write data.
- grant_o  out  NUM_REQUESTERS  one-hot owner; valid from the ACCESS entry cycle through DONE.
- done_o  out  NUM_REQUESTERS  one-cycle completion pulse to the owner.
- rdata_o  out  CSR_DATA_BUS_WIDTH  read result; valid when done_o is nonzero, held until the next capture.
- err_o  out  1  one-cycle pulse, concurrent with done_o, when sel ≥ CSR_STROBE_BUS_WIDTH.
- csr_stb_o  out  CSR_STROBE_BUS_WIDTH  one-hot write strobe.
- csr_data_o  out  CSR_DATA_BUS_WIDTH  latched write data.
- csr_data_i  in  CSR_STROBE_BUS_WIDTH*CSR_DATA_BUS_WIDTH  device read words; device i uses slice i.
- csr_rw_o  out  1  latched direction of the current transaction.
- csr_in_progress_o  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (async): state IDLE; all outputs 0; last_grant = NUM_REQUESTERS-1, so requester 0 has first priority.
- All outputs are registered.
- IDLE:
  - If req_i ≠ 0, pick the first set bit searching upward and cyclically from last_grant+1.
  - Latch the winner's rw, sel and wdata; set grant_o, csr_rw_o, csr_data_o; load counter = ACCESS_CYCLES-1; go to ACCESS.
  - If req_i = 0, stay in IDLE.
- ACCESS:
  - For a write with sel in range, csr_stb_o = 1<<sel for exactly the first ACCESS cycle, then 0.
  - Reads never assert a strobe.
  - On the cycle the counter reaches 0: for a read, rdata_o ← csr_data_i slice[sel], or 0 if sel is out of range; then go to DONE.
  - For writes, rdata_o is unchanged.
- DONE:
  - done_o = grant_o for one cycle; err_o = 1 if sel is out of range.
  - last_grant ← winner; go to IDLE; grant_o and csr_in_progress_o clear on exit.
- Latency: request sampled in IDLE cycle t; done_o at t+ACCESS_CYCLES+1.
- Back-to-back transactions are separated by at least one IDLE cycle.
- Requester rules:
  - Hold req_i and fields stable until done_o.
  - Deasserting req_i mid-transaction does not abort; the transaction completes and done_o still pulses.
  - A req_i still high after done_o is treated as a new request.
- Simultaneous requests: exactly one grant. With all requesters continuously active, the grant order is strictly cyclic, so no starvation.
- Out-of-range sel: no strobe, rdata_o = 0, err_o pulse, arbitration otherwise normal.
- Reset mid-ACCESS: immediate return to IDLE; strobe and grant drop asynchronously; no done_o.

Optional Feature:
- Macro CSR_BUS_ARBITER_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; last_grant is not used. Starvation of high indices under sustained load is accepted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single write: requester 2, rw=1, sel=5, wdata=0x1234, ACCESS_CYCLES=2 → csr_stb_o=0x20 for exactly 1 cycle with csr_data_o=0x1234; done_o=0b0100 at t+3; err_o=0.
- Single read: requester 0, sel=3, device 3 word=0xCAFE → csr_stb_o stays 0; rdata_o=0xCAFE when done_o=0b0001.
- Contention: all 4 requests held high for 8 transactions from reset → grant order 0,1,2,3,0,1,2,3; exactly one done_o bit per transaction. With FIXED_PRIORITY_EN, all 8 go to requester 0.
- Out of range: SEL_WIDTH=4, sel=9, read → no strobe; rdata_o=0; err_o and done_o pulse together.
- Reset mid-ACCESS during a write → csr_stb_o, grant_o, csr_in_progress_o go 0 without waiting for a clock; no done_o; next request is served normally, requester 0 first.
- Early release: requester 1 drops req_i in ACCESS → done_o=0b0010 still pulses; no second grant to requester 1.
